l2_data_responder: RTL

L2 side of the L1 D-cache request interface driven by the Memory stage. It serves L1 line reads (64-bit) and 32-bit half-line write-throughs from a direct-mapped, write-back, write-allocate L2 array, and refills from backing memory. It also accepts a secondary write client (other hart/task) and broadcasts `rewrite_active`/`rewrite_address` so the L1 invalidates stale lines.

---
 rtl/l2_data_responder_pkg.sv | 19 +
 rtl/l2_line_array.sv | 63 ++++++
 rtl/l2_data_responder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_data_responder_pkg.sv
// rtl/l2_data_responder_pkg.sv - shared types and constants for the L2 data responder
package l2_data_responder_pkg;

  localparam int LINE_ADDR_W           = 29;
  localparam int L2_INDEX_BITS_DEFAULT = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } state_e;

  function automatic int tag_width(input int index_bits);
    return LINE_ADDR_W - index_bits;
  endfunction

endpackage

// File: rtl/l2_line_array.sv
// rtl/l2_line_array.sv - direct-mapped L2 line storage with registered read and one write port
module l2_line_array
  import l2_data_responder_pkg::*;
#(
  parameter int INDEX_BITS = L2_INDEX_BITS_DEFAULT,
  parameter int TAG_W      = tag_width(L2_INDEX_BITS_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [63:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic                  wr_valid,
  input  logic                  wr_dirty,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [63:0]           wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [63:0]      data_q [LINES];

  // Only the state bits are cleared by reset; tag/data are don't-care while invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= wr_valid;
      dirty_q[wr_index] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
      rd_tag   <= '0;
      rd_data  <= '0;
    end else if (rd_en) begin
      rd_valid <= valid_q[rd_index];
      rd_dirty <= dirty_q[rd_index];
      rd_tag   <= tag_q[rd_index];
      rd_data  <= data_q[rd_index];
    end
  end

endmodule

// File: rtl/l2_data_responder.sv
// rtl/l2_data_responder.sv - L2 responder serving L1 line reads/write-throughs and a secondary writer
module l2_data_responder
  import l2_data_responder_pkg::*;
#(
  parameter int L2_INDEX_BITS = L2_INDEX_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   read_request_active,
  input  logic                   write_request_active,
  input  logic                   address_start_end_same,
  input  logic [LINE_ADDR_W-1:0] address_to_L2,
  input  logic                   refresh_data_loc,
  input  logic [31:0]            refresh_data_to_L2,
  output logic                   L2_operate_ready,
  output logic [63:0]            data_from_L2,
  input  logic                   ext_wr_valid,
  input  logic [LINE_ADDR_W-1:0] ext_wr_addr,
  input  logic                   ext_wr_loc,
  input  logic [31:0]            ext_wr_data,
  output logic                   ext_wr_ready,
  output logic                   rewrite_active,
  output logic [LINE_ADDR_W-1:0] rewrite_address,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [63:0]            mem_wdata,
  input  logic                   mem_ack,
  input  logic [63:0]            mem_rdata
);

  localparam int TAG_W = tag_width(L2_INDEX_BITS);

  state_e                 state_q, state_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic                   loc_q, loc_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   is_write_q, is_write_d;
  logic                   is_ext_q, is_ext_d;
  logic                   last_ext_q, last_ext_d;
  logic [63:0]            line_q, line_d;

  logic                     rd_valid, rd_dirty;
  logic [TAG_W-1:0]         rd_tag;
  logic [63:0]              rd_data;
  logic                     wr_en, wr_valid, wr_dirty;
  logic [TAG_W-1:0]         wr_tag;
  logic [63:0]              wr_data;
  logic [L2_INDEX_BITS-1:0] wr_index;

  logic                   l1_pending, grant_l1, grant_ext, hit, l1_still_wants;
  logic [LINE_ADDR_W-1:0] req_addr;
  logic [63:0]            merged;
  logic                   unused_start_end;

  assign unused_start_end = address_start_end_same;

  // Contention alternates; last_ext_q resets high so the L1 is served first.
  assign l1_pending = read_request_active | write_request_active;
  assign grant_l1   = l1_pending & (~ext_wr_valid | last_ext_q);
  assign grant_ext  = ext_wr_valid & ~grant_l1;
  assign req_addr   = grant_l1 ? address_to_L2 : ext_wr_addr;

  assign hit = rd_valid && (rd_tag == addr_q[LINE_ADDR_W-1:L2_INDEX_BITS]);
  assign l1_still_wants = (is_write_q ? write_request_active : read_request_active)
                          && (address_to_L2 == addr_q);

  always_comb begin
    merged = line_q;
    if (is_write_q) begin
      if (loc_q) merged[63:32] = wdata_q;
      else       merged[31:0]  = wdata_q;
    end
  end

  l2_line_array #(
    .INDEX_BITS(L2_INDEX_BITS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (state_q == ST_IDLE),
    .rd_index (req_addr[L2_INDEX_BITS-1:0]),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (wr_index),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      loc_q      <= 1'b0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      is_ext_q   <= 1'b0;
      last_ext_q <= 1'b1;
      line_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      loc_q      <= loc_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      is_ext_q   <= is_ext_d;
      last_ext_q <= last_ext_d;
      line_q     <= line_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    loc_d            = loc_q;
    wdata_d          = wdata_q;
    is_write_d       = is_write_q;
    is_ext_d         = is_ext_q;
    last_ext_d       = last_ext_q;
    line_d           = line_q;
    wr_en            = 1'b0;
    wr_index         = addr_q[L2_INDEX_BITS-1:0];
    wr_valid         = 1'b1;
    wr_dirty         = 1'b0;
    wr_tag           = addr_q[LINE_ADDR_W-1:L2_INDEX_BITS];
    wr_data          = merged;
    L2_operate_ready = 1'b0;
    data_from_L2     = '0;
    ext_wr_ready     = 1'b0;
    rewrite_active   = 1'b0;
    rewrite_address  = '0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;

    case (state_q)
      ST_IDLE: begin
        if (grant_l1 || grant_ext) begin
          addr_d     = req_addr;
          loc_d      = grant_l1 ? refresh_data_loc : ext_wr_loc;
          wdata_d    = grant_l1 ? refresh_data_to_L2 : ext_wr_data;
          is_write_d = grant_l1 ? ~read_request_active : 1'b1;
          is_ext_d   = grant_ext;
          last_ext_d = grant_ext;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit) begin
          line_d  = rd_data;
          state_d = ST_RESPOND;
        end else if (rd_valid && rd_dirty) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag, addr_q[L2_INDEX_BITS-1:0]};
        mem_wdata = rd_data;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_tag  = rd_tag;
          wr_data = rd_data;
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_data = mem_rdata;
          line_d  = mem_rdata;
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (is_write_q) begin
          wr_en    = 1'b1;
          wr_dirty = 1'b1;
        end
        // An L1 that withdrew or moved on gets no pulse; the line is still updated.
        L2_operate_ready = ~is_ext_q & l1_still_wants;
        data_from_L2     = merged;
        ext_wr_ready     = is_ext_q;
        rewrite_active   = is_ext_q;
        rewrite_address  = is_ext_q ? addr_q : '0;
        state_d          = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
